// File: rtl/vector_mem_port_arbiter.sv
// Shares one memory port between the vector memory unit (port 0) and the scalar load/store path (port 1).
// Counts in-flight reads so that each in-order response is returned to the requester that issued it.
module vector_mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  v_valid_rd,
    input  logic                  v_valid_wr,
    input  logic [ADDR_WIDTH-1:0] v_address,
    input  logic [DATA_WIDTH-1:0] v_data_wr,
    input  logic                  v_op_done,
    output logic                  v_ready,
    output logic                  v_valid_o,
    output logic [DATA_WIDTH-1:0] v_data_o,
    input  logic                  s_valid_rd,
    input  logic                  s_valid_wr,
    input  logic [ADDR_WIDTH-1:0] s_address,
    input  logic [DATA_WIDTH-1:0] s_data_wr,
    output logic                  s_ready,
    output logic                  s_valid_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    output logic                  mem_valid_rd,
    output logic                  mem_valid_wr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_wr,
    input  logic                  mem_ready,
    input  logic                  mem_valid_o,
    input  logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  err_sticky
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic OWN_VEC = 1'b0;
    localparam logic OWN_SCA = 1'b1;

    typedef enum logic [1:0] {IDLE, VEC, SCA, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic          err_q, err_d;

    logic                  activeState, respValid, fwdEn;
    logic                  selRd, selWr, acceptRd, acceptAny, reqV, reqS;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selData;

    // A response arriving while full frees a slot in the same cycle, so a new read may go out with it.
    assign activeState = (state_q == VEC) || (state_q == SCA);
    assign respValid   = mem_valid_o && (outstanding_q != '0);
    assign fwdEn       = activeState && ((outstanding_q < MAX_CNT) || respValid);

    assign selRd   = (owner_q == OWN_SCA) ? s_valid_rd : v_valid_rd;
    assign selWr   = (owner_q == OWN_SCA) ? s_valid_wr : v_valid_wr;
    assign selAddr = (owner_q == OWN_SCA) ? s_address  : v_address;
    assign selData = (owner_q == OWN_SCA) ? s_data_wr  : v_data_wr;

    assign mem_valid_rd = fwdEn & selRd;
    assign mem_valid_wr = fwdEn & selWr & ~selRd;
    assign mem_address  = (state_q == IDLE) ? '0 : selAddr;
    assign mem_data_wr  = (state_q == IDLE) ? '0 : selData;

    assign v_ready = mem_ready & fwdEn & (owner_q == OWN_VEC);
    assign s_ready = mem_ready & fwdEn & (owner_q == OWN_SCA);

    assign acceptRd  = mem_valid_rd & mem_ready;
    assign acceptAny = acceptRd | (mem_valid_wr & mem_ready);

    assign v_valid_o  = respValid & (owner_q == OWN_VEC);
    assign s_valid_o  = respValid & (owner_q == OWN_SCA);
    assign v_data_o   = v_valid_o ? mem_data_o : '0;
    assign s_data_o   = s_valid_o ? mem_data_o : '0;
    assign err_sticky = err_q;

    assign reqV = v_valid_rd | v_valid_wr;
    assign reqS = s_valid_rd | s_valid_wr;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        outstanding_d = outstanding_q;
        err_d         = err_q | (mem_valid_o && (outstanding_q == '0)) | (fwdEn && selRd && selWr);

        if (acceptRd && !respValid) begin
            outstanding_d = outstanding_q + ONE;
        end else if (!acceptRd && respValid) begin
            outstanding_d = outstanding_q - ONE;
        end

        case (state_q)
            IDLE: begin
                if (reqV && (!reqS || last_grant_q == OWN_SCA)) begin
                    state_d      = VEC;
                    owner_d      = OWN_VEC;
                    last_grant_d = OWN_VEC;
                end else if (reqS) begin
                    state_d      = SCA;
                    owner_d      = OWN_SCA;
                    last_grant_d = OWN_SCA;
                end
            end
            VEC: begin
                if (v_op_done) begin
                    state_d = (outstanding_d == '0) ? IDLE : DRAIN;
                end
            end
            SCA: begin
                if (acceptAny) begin
                    state_d = acceptRd ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (outstanding_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_VEC;
            last_grant_q  <= OWN_SCA;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end
endmodule

// File: tb/tb_vector_mem_port_arbiter.sv
// Directed bench for vector_mem_port_arbiter: arbitration, forwarding, back-pressure, drain and error handling.
// Inputs change #1 after the rising edge; combinational outputs are checked before the next edge.
module tb_vector_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        v_valid_rd, v_valid_wr, v_op_done, v_ready, v_valid_o;
    logic [31:0] v_address, v_data_wr, v_data_o;
    logic        s_valid_rd, s_valid_wr, s_ready, s_valid_o;
    logic [31:0] s_address, s_data_wr, s_data_o;
    logic        mem_valid_rd, mem_valid_wr, mem_ready, mem_valid_o, err_sticky;
    logic [31:0] mem_address, mem_data_wr, mem_data_o;

    int errors = 0;
    int checks = 0;

    vector_mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .v_valid_rd(v_valid_rd), .v_valid_wr(v_valid_wr), .v_address(v_address),
        .v_data_wr(v_data_wr), .v_op_done(v_op_done), .v_ready(v_ready),
        .v_valid_o(v_valid_o), .v_data_o(v_data_o),
        .s_valid_rd(s_valid_rd), .s_valid_wr(s_valid_wr), .s_address(s_address),
        .s_data_wr(s_data_wr), .s_ready(s_ready), .s_valid_o(s_valid_o), .s_data_o(s_data_o),
        .mem_valid_rd(mem_valid_rd), .mem_valid_wr(mem_valid_wr), .mem_address(mem_address),
        .mem_data_wr(mem_data_wr), .mem_ready(mem_ready), .mem_valid_o(mem_valid_o),
        .mem_data_o(mem_data_o), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        v_valid_rd = 0; v_valid_wr = 0; v_address = '0; v_data_wr = '0; v_op_done = 0;
        s_valid_rd = 0; s_valid_wr = 0; s_address = '0; s_data_wr = '0;
        mem_ready = 0; mem_valid_o = 0; mem_data_o = '0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        mem_ready = 1;
        #2;
        checks++; if (v_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_v_ready got=%b exp=0", v_ready); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if ({mem_valid_rd, mem_valid_wr} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_valid got=%b exp=00", {mem_valid_rd, mem_valid_wr}); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_address got=%h exp=0", mem_address); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err_sticky); end
        tick();
        rst = 1'b0;
        mem_ready = 0;
    endtask

    task automatic test_vector_read();
        v_valid_rd = 1; v_address = 32'h100; mem_ready = 1;
        #1;
        checks++; if (mem_valid_rd !== 1'b0) begin errors++; $display("[TB] FAIL t1_idle_no_fwd got=%b exp=0", mem_valid_rd); end
        tick();
        checks++; if (mem_valid_rd !== 1'b1) begin errors++; $display("[TB] FAIL t1_mem_valid_rd got=%b exp=1", mem_valid_rd); end
        checks++; if (mem_address !== 32'h100) begin errors++; $display("[TB] FAIL t1_mem_address got=%h exp=100", mem_address); end
        checks++; if (v_ready !== 1'b1) begin errors++; $display("[TB] FAIL t1_v_ready got=%b exp=1", v_ready); end
        tick();
        v_valid_rd = 0; mem_valid_o = 1; mem_data_o = 32'hCAFE;
        #1;
        checks++; if (v_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL t1_v_valid_o got=%b exp=1", v_valid_o); end
        checks++; if (v_data_o !== 32'hCAFE) begin errors++; $display("[TB] FAIL t1_v_data_o got=%h exp=cafe", v_data_o); end
        checks++; if (s_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_s_valid_o got=%b exp=0", s_valid_o); end
        tick();
        mem_valid_o = 0; v_op_done = 1;
        tick();
        v_op_done = 0;
        #1;
        checks++; if (v_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_back_idle got=%b exp=0", v_ready); end
        mem_ready = 0;
    endtask

    task automatic test_arbitration();
        doReset();
        v_valid_wr = 1; v_address = 32'h200; v_data_wr = 32'hAAAA;
        s_valid_wr = 1; s_address = 32'h300; s_data_wr = 32'h5555;
        tick();
        checks++; if (mem_address !== 32'h200) begin errors++; $display("[TB] FAIL t2_vec_first got=%h exp=200", mem_address); end
        checks++; if (mem_valid_wr !== 1'b1) begin errors++; $display("[TB] FAIL t2_vec_wr got=%b exp=1", mem_valid_wr); end
        v_op_done = 1;
        tick();
        v_op_done = 0;
        #1;
        checks++; if (mem_valid_wr !== 1'b0 || mem_address !== 32'h0) begin errors++; $display("[TB] FAIL t2_idle got=%b/%h exp=0/0", mem_valid_wr, mem_address); end
        tick();
        mem_ready = 1;
        #1;
        checks++; if (mem_address !== 32'h300 || mem_data_wr !== 32'h5555) begin errors++; $display("[TB] FAIL t2_sca_next got=%h/%h exp=300/5555", mem_address, mem_data_wr); end
        checks++; if (s_ready !== 1'b1 || v_ready !== 1'b0) begin errors++; $display("[TB] FAIL t2_sca_ready got=%b%b exp=10", s_ready, v_ready); end
        tick();
        mem_ready = 0;
        #1;
        checks++; if (mem_valid_wr !== 1'b0) begin errors++; $display("[TB] FAIL t2_sca_done got=%b exp=0", mem_valid_wr); end
        tick();
        checks++; if (mem_address !== 32'h200) begin errors++; $display("[TB] FAIL t2_vec_again got=%h exp=200", mem_address); end
        clearInputs();
        v_op_done = 1;
        tick();
        v_op_done = 0;
    endtask

    task automatic test_backpressure_drain();
        v_valid_rd = 1; v_address = 32'h400; mem_ready = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (v_ready !== 1'b1) begin errors++; $display("[TB] FAIL t3_accept%0d got=%b exp=1", i, v_ready); end
            tick();
        end
        checks++; if (v_ready !== 1'b0 || mem_valid_rd !== 1'b0) begin errors++; $display("[TB] FAIL t3_full got=%b%b exp=00", v_ready, mem_valid_rd); end
        mem_valid_o = 1; mem_data_o = 32'h11;
        #1;
        checks++; if (v_ready !== 1'b1 || mem_valid_rd !== 1'b1) begin errors++; $display("[TB] FAIL t3_fifth got=%b%b exp=11", v_ready, mem_valid_rd); end
        checks++; if (v_data_o !== 32'h11) begin errors++; $display("[TB] FAIL t3_resp got=%h exp=11", v_data_o); end
        tick();
        v_valid_rd = 0;
        mem_data_o = 32'h22;
        tick();
        mem_data_o = 32'h33;
        tick();
        mem_valid_o = 0;
        v_op_done = 1; s_valid_wr = 1; s_address = 32'h500; s_data_wr = 32'hBEEF;
        tick();
        v_op_done = 0;
        #1;
        checks++; if (s_ready !== 1'b0 || mem_valid_wr !== 1'b0) begin errors++; $display("[TB] FAIL t4_drain_hold got=%b%b exp=00", s_ready, mem_valid_wr); end
        mem_valid_o = 1; mem_data_o = 32'h44;
        #1;
        checks++; if (v_valid_o !== 1'b1 || v_data_o !== 32'h44 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_drain_resp1 got=%b/%h/%b exp=1/44/0", v_valid_o, v_data_o, s_ready); end
        tick();
        mem_data_o = 32'h55;
        #1;
        checks++; if (v_data_o !== 32'h55 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_drain_resp2 got=%h/%b exp=55/0", v_data_o, s_ready); end
        tick();
        mem_valid_o = 0;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_idle got=%b exp=0", s_ready); end
        tick();
        checks++; if (s_ready !== 1'b1 || mem_valid_wr !== 1'b1 || mem_address !== 32'h500 || mem_data_wr !== 32'hBEEF) begin
            errors++; $display("[TB] FAIL t4_sca_write got=%b%b/%h/%h exp=11/500/beef", s_ready, mem_valid_wr, mem_address, mem_data_wr);
        end
        tick();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_sca_idle got=%b exp=0", s_ready); end
        s_valid_wr = 0;
        tick();
    endtask

    task automatic test_scalar_read();
        s_valid_rd = 1; s_address = 32'h600; mem_ready = 1;
        tick();
        checks++; if (mem_valid_rd !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("[TB] FAIL t5_accept got=%b%b exp=11", mem_valid_rd, s_ready); end
        tick();
        s_valid_rd = 0;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL t5_drain got=%b exp=0", s_ready); end
        mem_valid_o = 1; mem_data_o = 32'h77;
        #1;
        checks++; if (s_valid_o !== 1'b1 || s_data_o !== 32'h77) begin errors++; $display("[TB] FAIL t5_s_resp got=%b/%h exp=1/77", s_valid_o, s_data_o); end
        checks++; if (v_valid_o !== 1'b0 || v_data_o !== 32'h0) begin errors++; $display("[TB] FAIL t5_v_quiet got=%b/%h exp=0/0", v_valid_o, v_data_o); end
        tick();
        mem_valid_o = 0; mem_ready = 0; v_valid_rd = 1; v_address = 32'h700;
        #1;
        checks++; if (mem_valid_rd !== 1'b0) begin errors++; $display("[TB] FAIL t5_idle got=%b exp=0", mem_valid_rd); end
        tick();
        checks++; if (mem_valid_rd !== 1'b1 || mem_address !== 32'h700) begin errors++; $display("[TB] FAIL t5_vec_grant got=%b/%h exp=1/700", mem_valid_rd, mem_address); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL t5_no_err got=%b exp=0", err_sticky); end
        clearInputs();
        v_op_done = 1;
        tick();
        v_op_done = 0;
    endtask

    task automatic test_errors();
        mem_valid_o = 1; mem_data_o = 32'h99;
        #1;
        checks++; if (v_valid_o !== 1'b0 || s_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL t6_stray_drop got=%b%b exp=00", v_valid_o, s_valid_o); end
        tick();
        mem_valid_o = 0;
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL t6_err_set got=%b exp=1", err_sticky); end
        v_valid_rd = 1; v_address = 32'h800; mem_ready = 1;
        tick();
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1; v_valid_rd = 0;
        #1;
        checks++; if ({v_ready, s_ready, mem_valid_rd, mem_valid_wr, v_valid_o, s_valid_o} !== 6'b0) begin
            errors++; $display("[TB] FAIL t6_rst_outputs got=%b exp=000000", {v_ready, s_ready, mem_valid_rd, mem_valid_wr, v_valid_o, s_valid_o});
        end
        checks++; if (err_sticky !== 1'b0 || mem_address !== 32'h0) begin errors++; $display("[TB] FAIL t6_rst_err got=%b/%h exp=0/0", err_sticky, mem_address); end
        tick();
        rst = 1'b0;
        mem_valid_o = 1; mem_data_o = 32'h123;
        #1;
        checks++; if (v_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL t6_post_rst_drop got=%b exp=0", v_valid_o); end
        tick();
        mem_valid_o = 0;
        tick();
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL t6_post_rst_err got=%b exp=1", err_sticky); end
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        test_reset();
        test_vector_read();
        test_arbitration();
        test_backpressure_drain();
        test_scalar_read();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
